// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side logic.
// State encodings, a constant-foldable clog2 and default widths.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_MAX  = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set bit of req at or after
// start, wrapping; returns one-hot, index and any_valid.
module rr_priority_picker
    import fifo_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    int j;

    always_comb begin
        onehot    = '0;
        idx       = '0;
        any_valid = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_valid && req[j]) begin
                any_valid = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware owner of the async FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add saturating stall/grant counters.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int BURST_MAX  = DEF_BURST_MAX,
    localparam int IW         = clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [IW-1:0]                 grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   grant_cnt,
`endif
    output logic                          busy
);

    localparam int BW = clog2(BURST_MAX + 1);

    arb_state_t           state, state_nx;
    logic [IW-1:0]        owner, owner_nx;
    logic [NUM_REQ-1:0]   owner_oh, owner_oh_nx;
    logic [IW-1:0]        rr_ptr, rr_ptr_nx;
    logic [BW-1:0]        beat_cnt, beat_cnt_nx;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 in_burst;
    logic                 own_valid;
    logic                 own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                 xfer;
    logic                 burst_done;
    logic [IW-1:0]        owner_inc;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req       (req_valid),
        .start     (rr_ptr),
        .onehot    (pick_oh),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    assign in_burst  = (state == BURST);
    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign own_data  = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
    assign xfer      = in_burst & own_valid & ~wfull;

    // Exit on last beat, on the BURST_MAX-th beat, or on owner release.
    assign burst_done = (xfer & (own_last |
                        (beat_cnt == BW'(BURST_MAX - 1))))
                      | (in_burst & ~own_valid);

    assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0
                                                   : owner + 1'b1;

    assign winc      = xfer;
    assign wdata     = xfer ? own_data : '0;
    assign req_ready = (in_burst & ~wfull) ? owner_oh : '0;
    assign grant_id  = owner;
    assign busy      = in_burst;

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        owner_oh_nx = owner_oh;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx    = BURST;
                    owner_nx    = pick_idx;
                    owner_oh_nx = pick_oh;
                end
            end
            BURST: begin
                if (burst_done) begin
                    state_nx    = IDLE;
                    rr_ptr_nx   = owner_inc;
                    beat_cnt_nx = '0;
                end else if (xfer) begin
                    beat_cnt_nx = beat_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            owner    <= '0;
            owner_oh <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            owner_oh <= owner_oh_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic stall_hit;
    logic grant_hit;

    assign stall_hit = in_burst & own_valid & wfull;
    assign grant_hit = (state == IDLE) & pick_any;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            if (stall_hit && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (grant_hit && grant_cnt != 16'hFFFF) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, beat
// scoreboard and hand-written reset/stats sequences.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 8;

    logic            wclk = 1'b0;
    logic            wrst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wfull = 1'b0;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]     stall_cnt;
    logic [15:0]     grant_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
        .stall_cnt (stall_cnt),
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic [3:0] rdy;
        logic       wi;
        logic [7:0] wd;
        logic [1:0] gid;
        logic       bz;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;

    vec_t tbl[23];
    exp_t sb[$];
    int   sent[N];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [3:0] v, input logic [3:0] l,
        input logic f, input logic [3:0] rdy,
        input logic wi, input logic [7:0] wd,
        input logic [1:0] gid, input logic bz);
        vec_t r;
        r.v = v; r.l = l; r.f = f; r.rdy = rdy;
        r.wi = wi; r.wd = wd; r.gid = gid; r.bz = bz;
        return r;
    endfunction

    task automatic set_lanes(input int k);
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = {4'(i + 1), 4'(k)};
    endtask

    // Inputs change 1ns after the edge, checks happen 4ns later.
    task automatic drive(input logic [3:0] v,
                         input logic [3:0] l,
                         input logic f);
        @(posedge wclk); #1;
        req_valid = v;
        req_last  = l;
        wfull     = f;
        #3;
    endtask

    task automatic do_reset();
        @(posedge wclk); #1;
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        wfull     = 1'b0;
        @(posedge wclk); #1;
        wrst_n = 1'b1;
    endtask

    initial begin
        // Single req0 burst, req2 release, req3 / wrap to req0,
        // req1 with five wfull stall cycles.
        tbl[0]  = mk(4'b0001, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        tbl[1]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 8'h11, 0, 1);
        tbl[2]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 8'h12, 0, 1);
        tbl[3]  = mk(4'b0001, 4'b0001, 0, 4'b0001, 1, 8'h13, 0, 1);
        tbl[4]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        tbl[5]  = mk(4'b0100, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        tbl[6]  = mk(4'b0100, 4'b0000, 0, 4'b0100, 1, 8'h36, 2, 1);
        tbl[7]  = mk(4'b1000, 4'b0000, 0, 4'b0100, 0, 8'h00, 2, 1);
        tbl[8]  = mk(4'b1001, 4'b0000, 0, 4'b0000, 0, 8'h00, 2, 0);
        tbl[9]  = mk(4'b1001, 4'b1000, 0, 4'b1000, 1, 8'h49, 3, 1);
        tbl[10] = mk(4'b0001, 4'b0000, 0, 4'b0000, 0, 8'h00, 3, 0);
        tbl[11] = mk(4'b0001, 4'b0001, 0, 4'b0001, 1, 8'h1B, 0, 1);
        tbl[12] = mk(4'b0010, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        tbl[13] = mk(4'b0010, 4'b0000, 0, 4'b0010, 1, 8'h2D, 1, 1);
        tbl[14] = mk(4'b0010, 4'b0000, 0, 4'b0010, 1, 8'h2E, 1, 1);
        for (int k = 15; k < 20; k++)
            tbl[k] = mk(4'b0010, 4'b0000, 1, 4'b0000, 0, 8'h00, 1, 1);
        tbl[20] = mk(4'b0010, 4'b0000, 0, 4'b0010, 1, 8'h24, 1, 1);
        tbl[21] = mk(4'b0010, 4'b0010, 0, 4'b0010, 1, 8'h25, 1, 1);
        tbl[22] = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 0);

        // Reset state
        #12;
        chk("rst_ready", req_ready, 0);
        chk("rst_winc", winc, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_busy", busy, 0);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("rst_stall", stall_cnt, 0);
        chk("rst_grant", grant_cnt, 0);
`endif
        @(posedge wclk); #1;
        wrst_n = 1'b1;

        for (int k = 0; k < 23; k++) begin
            set_lanes(k);
            drive(tbl[k].v, tbl[k].l, tbl[k].f);
            chk($sformatf("v%0d_ready", k), req_ready, tbl[k].rdy);
            chk($sformatf("v%0d_winc", k), winc, tbl[k].wi);
            chk($sformatf("v%0d_wdata", k), wdata, tbl[k].wd);
            chk($sformatf("v%0d_gid", k), grant_id, tbl[k].gid);
            chk($sformatf("v%0d_busy", k), busy, tbl[k].bz);
        end

        // All four streaming, no last: 0,1,2,3,0 x BURST_MAX beats.
        do_reset();
        for (int g = 0; g < 5; g++)
            for (int b = 0; b < BM; b++)
                sb.push_back('{id: 2'(g % N),
                               d: {4'(g % N), 4'((g / N) * BM + b)}});
        for (int i = 0; i < N; i++) sent[i] = 0;
        for (int cyc = 0; cyc < 100 && sb.size() != 0; cyc++) begin
            @(posedge wclk); #1;
            req_valid = 4'hF;
            req_last  = 4'h0;
            wfull     = 1'b0;
            for (int i = 0; i < N; i++)
                req_data[i*DW +: DW] = {4'(i), 4'(sent[i])};
            #3;
            if (winc) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_gid", grant_id, e.id);
                chk("sb_data", wdata, e.d);
                chk("sb_ready", req_ready, 4'b0001 << e.id);
            end
            for (int i = 0; i < N; i++)
                if (req_ready[i] && req_valid[i]) sent[i]++;
        end
        chk("sb_drain", sb.size(), 0);
        drive(4'b0011, 4'b0000, 0);
        chk("rr_idle_winc", winc, 0);
        chk("rr_idle_busy", busy, 0);
        drive(4'b0011, 4'b0000, 0);
        chk("rr_next_gid", grant_id, 1);
        chk("rr_next_busy", busy, 1);
        drive(4'b0000, 4'b0000, 0);
        chk("rr_release_winc", winc, 0);

        // Async reset in the middle of a req1 burst.
        do_reset();
        drive(4'b0010, 4'b0000, 0);
        drive(4'b0010, 4'b0000, 0);
        chk("ar_pre_winc", winc, 1);
        drive(4'b0010, 4'b0000, 0);
        chk("ar_pre_gid", grant_id, 1);
        #1;
        wrst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_winc", winc, 0);
        chk("ar_ready", req_ready, 0);
        chk("ar_wdata", wdata, 0);
        chk("ar_gid", grant_id, 0);
        @(posedge wclk); #1;
        wrst_n = 1'b1;
        #3;
        chk("ar_rel_busy", busy, 0);
        drive(4'b0010, 4'b0000, 0);
        chk("ar_regrant_gid", grant_id, 1);
        chk("ar_regrant_winc", winc, 1);
        drive(4'b0000, 4'b0000, 0);
        drive(4'b0000, 4'b0000, 0);
        chk("ar_end_busy", busy, 0);

`ifdef FIFO_WR_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            logic [3:0] m;
            m = 4'b0001 << k;
            drive(m, 4'b0000, 0);
            repeat (k == 0 ? 4 : 3) drive(m, 4'b0000, 1);
            drive(m, m, 0);
            drive(4'b0000, 4'b0000, 0);
        end
        chk("st_stall", stall_cnt, 10);
        chk("st_grant", grant_cnt, 3);
        drive(4'b0001, 4'b0000, 1);
        req_valid = 4'b0001;
        wfull     = 1'b1;
        repeat (70000) @(posedge wclk);
        #1;
        chk("st_stall_sat", stall_cnt, 16'hFFFF);
        chk("st_grant4", grant_cnt, 4);
        chk("st_hold_gid", grant_id, 0);
        chk("st_hold_busy", busy, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
